// File: rtl/paddle_ctrl.sv
// Vertical paddle controller for one Pong player.
// Manual mode: synchronised buttons with press-to-move and hold auto-repeat.
// Auto mode: the paddle steps toward target_y once per tracking period.
// The position is clamped to [0, SCREEN_H - PADDLE_H] and never wraps.
module paddle_ctrl #(
    parameter int unsigned Y_W           = 10,
    parameter int unsigned SCREEN_H      = 480,
    parameter int unsigned PADDLE_H      = 120,
    parameter int unsigned STEP          = 20,
    parameter int unsigned Y_RESET       = 180,
    parameter int unsigned REPEAT_DLY    = 5000000,
    parameter int unsigned REPEAT_PERIOD = 2500000,
    parameter int unsigned TRACK_PERIOD  = 2500000,
    parameter int unsigned DEADBAND      = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           mode,
    input  logic           btn_inc,
    input  logic           btn_dec,
    input  logic [Y_W-1:0] target_y,
    input  logic           recenter,
    output logic [Y_W-1:0] paddle_y,
    output logic           moved,
    output logic           at_top,
    output logic           at_bottom
);

    localparam int unsigned YMAX    = SCREEN_H - PADDLE_H;
    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PERIOD) ? REPEAT_DLY : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned TCNT_W  = $clog2(TRACK_PERIOD);

    // Two guard bits so sums and centre comparisons cannot overflow.
    localparam logic [Y_W+1:0] STEP_X = (Y_W+2)'(STEP);
    localparam logic [Y_W+1:0] YMAX_X = (Y_W+2)'(YMAX);
    localparam logic [Y_W+1:0] HALF_X = (Y_W+2)'(PADDLE_H / 2);
    localparam logic [Y_W+1:0] DB_X   = (Y_W+2)'(DEADBAND);

    localparam logic [CNT_W-1:0]  DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0]  PER_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [TCNT_W-1:0] TRK_LAST  = TCNT_W'(TRACK_PERIOD - 1);
    localparam logic [Y_W-1:0]    Y_RESET_V = Y_W'(Y_RESET);
    localparam logic [Y_W-1:0]    YMAX_V    = Y_W'(YMAX);
    localparam logic [Y_W-1:0]    STEP_V    = Y_W'(STEP);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    logic              inc_meta_q, inc_s_q, dec_meta_q, dec_s_q;
    logic              mode_q;
    state_e            state_q, state_d;
    logic              dir_q, dir_d;          // 1 = held direction is inc
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              moved_q, at_top_q, at_bottom_q;

    logic              dir_inc, dir_dec, still_held;
    logic              go_inc, go_dec;
    logic [Y_W+1:0]    y_x, sum_x, centre_x, tgt_x;
    logic [Y_W-1:0]    y_inc, y_dec;
    logic              want_inc, want_dec;

    assign dir_inc    = inc_s_q & ~dec_s_q;
    assign dir_dec    = dec_s_q & ~inc_s_q;
    assign still_held = dir_q ? dir_inc : dir_dec;

    assign y_x      = {2'b00, y_q};
    assign sum_x    = y_x + STEP_X;
    assign y_inc    = (sum_x > YMAX_X) ? YMAX_V : (y_q + STEP_V);
    assign y_dec    = (y_x < STEP_X) ? '0 : (y_q - STEP_V);
    assign centre_x = y_x + HALF_X;
    assign tgt_x    = {2'b00, target_y};
    assign want_inc = tgt_x > (centre_x + DB_X);
    assign want_dec = (tgt_x + DB_X) < centre_x;

    // Control: priority recenter > enable low > mode change > auto/manual move.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        tcnt_d  = '0;
        go_inc  = 1'b0;
        go_dec  = 1'b0;
        if (recenter || !enable || (mode != mode_q)) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (mode) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (tcnt_q == TRK_LAST) begin
                go_inc = want_inc;
                go_dec = want_dec;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (dir_inc || dir_dec) begin
                        go_inc  = dir_inc;
                        go_dec  = dir_dec;
                        dir_d   = dir_inc;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (!still_held) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == DLY_LAST) begin
                        go_inc  = dir_q;
                        go_dec  = ~dir_q;
                        cnt_d   = '0;
                        state_d = StRepeat;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRepeat: begin
                    if (!still_held) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == PER_LAST) begin
                        go_inc = dir_q;
                        go_dec = ~dir_q;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Datapath: next paddle position; moves at a limit leave it unchanged.
    always_comb begin
        y_d = y_q;
        if (recenter) begin
            y_d = Y_RESET_V;
        end else if (go_inc) begin
            y_d = y_inc;
        end else if (go_dec) begin
            y_d = y_dec;
        end
    end

    // State, synchronisers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_meta_q  <= 1'b0;
            inc_s_q     <= 1'b0;
            dec_meta_q  <= 1'b0;
            dec_s_q     <= 1'b0;
            mode_q      <= 1'b0;
            state_q     <= StIdle;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            y_q         <= Y_RESET_V;
            moved_q     <= 1'b0;
            at_top_q    <= (Y_RESET == 0);
            at_bottom_q <= (Y_RESET == YMAX);
        end else begin
            inc_meta_q  <= btn_inc;
            inc_s_q     <= inc_meta_q;
            dec_meta_q  <= btn_dec;
            dec_s_q     <= dec_meta_q;
            mode_q      <= mode;
            state_q     <= state_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            y_q         <= y_d;
            moved_q     <= (y_d != y_q);
            at_top_q    <= (y_d == '0);
            at_bottom_q <= (y_d == YMAX_V);
        end
    end

    assign paddle_y  = y_q;
    assign moved     = moved_q;
    assign at_top    = at_top_q;
    assign at_bottom = at_bottom_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomised bench for paddle_ctrl against a rule-level reference model.
// Short repeat/track periods; Y_RESET = 190 so clamping hits non-multiples of STEP.
module tb_paddle_ctrl;

    localparam int Y_W      = 10;
    localparam int SCREEN_H = 480;
    localparam int PADDLE_H = 120;
    localparam int STEP     = 20;
    localparam int Y_RESET  = 190;
    localparam int RD       = 8;
    localparam int RP       = 4;
    localparam int TP       = 4;
    localparam int DB       = 8;
    localparam int YMAX     = SCREEN_H - PADDLE_H;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b1;
    logic           mode = 1'b0;
    logic           btn_inc = 1'b0;
    logic           btn_dec = 1'b0;
    logic [Y_W-1:0] target_y = '0;
    logic           recenter = 1'b0;
    logic [Y_W-1:0] paddle_y;
    logic           moved, at_top, at_bottom;

    paddle_ctrl #(
        .Y_W(Y_W), .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .STEP(STEP), .Y_RESET(Y_RESET),
        .REPEAT_DLY(RD), .REPEAT_PERIOD(RP), .TRACK_PERIOD(TP), .DEADBAND(DB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .target_y(target_y), .recenter(recenter), .paddle_y(paddle_y),
        .moved(moved), .at_top(at_top), .at_bottom(at_bottom)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_y, m_moved;
    bit hist_inc[2], hist_dec[2];  // [0] newest raw sample, [1] the one the logic sees
    int run, run_dir, acnt;
    bit prev_mode;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp_move(input int y, input int d);
        int n;
        n = y + d * STEP;
        if (n > YMAX) n = YMAX;
        if (n < 0) n = 0;
        return n;
    endfunction

    task automatic model_reset();
        m_y = Y_RESET; m_moved = 0;
        hist_inc = '{0, 0}; hist_dec = '{0, 0};
        run = 0; run_dir = 0; acnt = 0; prev_mode = 0;
    endtask

    // One clock edge of the rules: dir seen two edges after the raw sample,
    // moves at run lengths 1, 1+RD, 1+RD+k*RP; auto decisions every TP edges.
    task automatic model_edge();
        int dir, ny, c;
        bit brk;
        dir = (hist_inc[1] && !hist_dec[1]) ? 1 : ((hist_dec[1] && !hist_inc[1]) ? -1 : 0);
        brk = recenter || !enable || (mode != prev_mode);
        ny = m_y;
        if (recenter) ny = Y_RESET;
        if (brk || mode || dir == 0) run = 0;
        else if (run > 0 && dir != run_dir) run = 0;
        else begin
            run_dir = dir;
            run++;
            if (run == 1 || (run - 1 >= RD && (run - 1 - RD) % RP == 0))
                ny = clamp_move(m_y, dir);
        end
        if (brk || !mode) acnt = 0;
        else begin
            acnt++;
            if (acnt % TP == 0) begin
                c = m_y + PADDLE_H / 2;
                if (int'(target_y) > c + DB) ny = clamp_move(m_y, 1);
                else if (int'(target_y) + DB < c) ny = clamp_move(m_y, -1);
            end
        end
        m_moved = (ny != m_y);
        m_y = ny;
        prev_mode = mode;
        hist_inc[1] = hist_inc[0]; hist_inc[0] = btn_inc;
        hist_dec[1] = hist_dec[0]; hist_dec[0] = btn_dec;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
        check_eq("paddle_y", paddle_y, m_y);
        check_eq("moved", moved, m_moved);
        check_eq("at_top", at_top, m_y == 0);
        check_eq("at_bottom", at_bottom, m_y == YMAX);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset_check();
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_y", paddle_y, Y_RESET);
        check_eq("async_rst_moved", moved, 0);
        check_eq("async_rst_top", at_top, 0);
        check_eq("async_rst_bottom", at_bottom, 0);
        model_reset();
        ticks(2);
        reset = 1'b1;
    endtask

    function automatic logic [Y_W-1:0] near_centre();
        int t;
        t = m_y + PADDLE_H / 2 + $urandom_range(0, 24) - 12;
        if (t < 0) t = 0;
        if (t > 1023) t = 1023;
        return Y_W'(t);
    endfunction

    initial begin
        model_reset();
        ticks(2);
        reset = 1'b1;
        ticks(2);

        // Single short press, then a long hold into the bottom clamp.
        btn_inc = 1'b1; ticks(3); btn_inc = 1'b0; ticks(12);
        btn_inc = 1'b1; ticks(50); btn_inc = 1'b0; ticks(4);
        async_reset_check();
        ticks(2);

        // Both buttons, frozen dec with enable low, then resume.
        btn_inc = 1'b1; btn_dec = 1'b1; ticks(20);
        btn_inc = 1'b0; enable = 1'b0; ticks(10);
        enable = 1'b1; ticks(60);
        btn_dec = 1'b0; ticks(3);
        recenter = 1'b1; tick(); recenter = 1'b0; ticks(2);

        // Auto tracking toward a far target, then inside the deadband.
        mode = 1'b1; target_y = 10'd400; ticks(30);
        target_y = near_centre(); ticks(12);
        recenter = 1'b1; tick(); recenter = 1'b0;
        target_y = 10'd5; ticks(30);
        mode = 1'b0; ticks(3);

        // Randomised segments covering all modes and control inputs.
        for (int seg = 0; seg < 160; seg++) begin
            int len, pat;
            len = $urandom_range(1, 30);
            pat = $urandom_range(0, 5);
            btn_inc = (pat == 1 || pat == 3 || pat == 5);
            btn_dec = (pat == 2 || pat == 3 || pat == 4);
            if ($urandom_range(0, 3) == 0) mode = ~mode;
            target_y = ($urandom_range(0, 1) == 0) ? near_centre() : Y_W'($urandom_range(0, 1023));
            for (int i = 0; i < len; i++) begin
                enable   = ($urandom_range(0, 11) != 0);
                recenter = ($urandom_range(0, 39) == 0);
                if (mode && $urandom_range(0, 7) == 0) target_y = near_centre();
                if ($urandom_range(0, 15) == 0) btn_inc = ~btn_inc;
                tick();
            end
            recenter = 1'b0;
            if (seg == 80) async_reset_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
